// File: rtl/sr_latch_sched.sv
// Round-robin scheduler sharing a bank of SR latch cells between several requesters.
// Each grant becomes one set/reset pulse, followed by a settle cycle and a Q read-back.
module sr_latch_sched #(
    parameter int REQ_N   = 4,
    parameter int LATCH_N = 8,
    parameter int IDX_W   = 3,
    parameter int PULSE_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [REQ_N-1:0]         req_i,
    input  logic [REQ_N-1:0]         op_i,
    input  logic [REQ_N*IDX_W-1:0]   idx_i,
    input  logic [LATCH_N-1:0]       Q_i,
    output logic [LATCH_N-1:0]       S_o,
    output logic [LATCH_N-1:0]       R_o,
    output logic [REQ_N-1:0]         gnt_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     busy_o
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);

    logic [1:0]         state_q;
    logic [3:0]         cnt_q;
    logic [PTR_W-1:0]   last_q;
    logic               op_q;
    logic [IDX_W-1:0]   idx_q;
    logic               idx_ok_q;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick;
    logic               pick_op;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;

    logic [LATCH_N-1:0] pulse_mask;
    logic               q_sel;

    // Search begins one past the last winner so every requester is served in turn.
    always_comb begin
        pick_valid = 1'b0;
        pick       = last_q;
        pick_op    = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= REQ_N; i++) begin
            cand = (int'(last_q) + i) % REQ_N;
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick       = PTR_W'(cand);
                pick_op    = op_i[cand];
                pick_idx   = idx_i[cand*IDX_W +: IDX_W];
            end
        end
    end

    // An out-of-range index selects no cell, so nothing is pulsed and no Q is read.
    always_comb begin
        pulse_mask = '0;
        q_sel      = 1'b0;
        for (int j = 0; j < LATCH_N; j++) begin
            if (idx_ok_q && (idx_q == IDX_W'(j))) begin
                pulse_mask[j] = 1'b1;
                q_sel         = Q_i[j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= PTR_W'(REQ_N - 1);
            op_q     <= 1'b0;
            idx_q    <= '0;
            idx_ok_q <= 1'b0;
            S_o      <= '0;
            R_o      <= '0;
            gnt_o    <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            S_o    <= '0;
            R_o    <= '0;
            gnt_o  <= '0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    busy_o <= pick_valid;
                    if (pick_valid) begin
                        state_q  <= ST_PULSE;
                        last_q   <= pick;
                        op_q     <= pick_op;
                        idx_q    <= pick_idx;
                        idx_ok_q <= (int'(pick_idx) < LATCH_N);
                    end
                end
                ST_PULSE: begin
                    if (op_q) begin
                        S_o <= pulse_mask;
                    end else begin
                        R_o <= pulse_mask;
                    end
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == PULSE_LAST) begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_o  <= 1'b1;
                    gnt_o   <= REQ_N'(1) << last_q;
                    err_o   <= !idx_ok_q || (q_sel != op_q);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
